// File: rtl/adc_pll_ctrl_pkg.sv
// Shared types and defaults for the ADC sampling PLL sequencer.
package adc_pll_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;

  localparam int unsigned DEF_RST_CYCLES    = 32;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 24000;
  localparam int unsigned DEF_STABLE_CYCLES = 256;
  localparam int unsigned DEF_MAX_RETRY     = 3;
  localparam int unsigned DEF_CNT_W         = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

endpackage

// File: rtl/adc_pll_ctrl_sync_2ff.sv
// Double-flop synchronizer for asynchronous level inputs, flops reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_pll_ctrl.sv
// PLL reset sequencer: bounded lock retries, lock qualification, clk_ok
// release for the ADC datapath, sticky lock-loss and fault reporting.
module adc_pll_ctrl
  import adc_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               sw_reset,
  input  logic               fault_clr,
  output logic               pll_rst,
  output logic               clk_ok,
  output logic               lock_lost,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_rst_q, clk_ok_q, fault_q;
  logic               lock_s;
  logic               fail;
  logic               lost;
  logic               restart;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // Next-state, retry accounting and sticky lock-loss flag.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    lost    = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) fail = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr || sw_reset) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (fail) begin
      if (retry_q >= RETRY_W'(MAX_RETRY)) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_RESET;
      end
    end

    // Software restart overrides everything except the FAULT hold.
    if (sw_reset && (state_q != ST_FAULT)) begin
      state_d = ST_RESET;
      retry_d = '0;
    end

    restart = (state_d != state_q) || (sw_reset && (state_q != ST_FAULT));
    if (restart) cnt_d = '0;
    else if (state_q inside {ST_RESET, ST_WAIT_LOCK, ST_STABLE}) cnt_d = cnt_q + CNT_W'(1);
    else cnt_d = cnt_q;

    if (lost) lock_lost_d = 1'b1;
    else if (fault_clr) lock_lost_d = 1'b0;
    else lock_lost_d = lock_lost_q;
  end

  // State and Moore outputs decoded from next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      clk_ok_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      clk_ok_q    <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign clk_ok    = clk_ok_q;
  assign lock_lost = lock_lost_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_adc_pll_ctrl.sv
// Directed self-checking bench for adc_pll_ctrl with shortened timing parameters.
module tb_adc_pll_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pll_rst;
  logic       clk_ok;
  logic       lock_lost;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  logic saw_clk_ok = 1'b0;

  adc_pll_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .CNT_W         (16)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .sw_reset   (sw_reset),
    .fault_clr  (fault_clr),
    .pll_rst    (pll_rst),
    .clk_ok     (clk_ok),
    .lock_lost  (lock_lost),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) if (clk_ok === 1'b1) saw_clk_ok = 1'b1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic wait_pll_rst(input logic v, output int n);
    n = 0;
    while (pll_rst !== v && n < 200) begin tick(1); n++; end
  endtask

  task automatic wait_clk_ok(input logic v, output int n);
    n = 0;
    while (clk_ok !== v && n < 200) begin tick(1); n++; end
  endtask

  task automatic wait_state(input logic [2:0] v, output int n);
    n = 0;
    while (state !== v && n < 200) begin tick(1); n++; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw_reset = 1'b0;
    fault_clr = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    saw_clk_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    checks++; if (clk_ok !== 1'b0) begin errors++; $display("FAIL reset_clk_ok: got %b want 0", clk_ok); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_happy();
    int n;
    pll_locked = 1'b0;
    do_reset();
    wait_pll_rst(1'b0, n);
    checks++; if (n != 4) begin errors++; $display("FAIL happy_rst_len: got %0d want 4", n); end
    tick(6);
    pll_locked = 1'b1;
    wait_clk_ok(1'b1, n);
    checks++; if (n != 11) begin errors++; $display("FAIL happy_clk_ok_lat: got %0d want 11", n); end
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL happy_state: got %0d want 3", state); end
    checks++; if (retry_cnt !== 4'd0 || fault !== 1'b0 || pll_rst !== 1'b0) begin
      errors++; $display("FAIL happy_status: retry %0d fault %b pll_rst %b want 0 0 0", retry_cnt, fault, pll_rst);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    wait_clk_ok(1'b0, n);
    checks++; if (n != 3) begin errors++; $display("FAIL loss_clk_ok_fall: got %0d want 3", n); end
    checks++; if (lock_lost !== 1'b1 || state !== 3'd0 || pll_rst !== 1'b1 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL loss_status: lost %b state %0d pll_rst %b retry %0d want 1 0 1 0", lock_lost, state, pll_rst, retry_cnt);
    end
    wait_pll_rst(1'b0, n);
    checks++; if (n != 4) begin errors++; $display("FAIL loss_rst_len: got %0d want 4", n); end
    pll_locked = 1'b1;
    wait_clk_ok(1'b1, n);
    checks++; if (n != 11) begin errors++; $display("FAIL relock_lat: got %0d want 11", n); end
    checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL relock_sticky: got %b want 1", lock_lost); end
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++; if (lock_lost !== 1'b0 || clk_ok !== 1'b1) begin
      errors++; $display("FAIL lost_clear: lost %b clk_ok %b want 0 1", lock_lost, clk_ok);
    end
  endtask

  task automatic test_simultaneous();
    pll_locked = 1'b0;
    tick(2);
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    checks++; if (state !== 3'd0 || lock_lost !== 1'b1 || retry_cnt !== 4'd0 || clk_ok !== 1'b0) begin
      errors++; $display("FAIL sw_and_loss: state %0d lost %b retry %0d clk_ok %b want 0 1 0 0", state, lock_lost, retry_cnt, clk_ok);
    end
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL sw_loss_clear: got %b want 0", lock_lost); end
  endtask

  task automatic test_no_lock();
    pll_locked = 1'b0;
    do_reset();
    tick(24);
    checks++; if (retry_cnt !== 4'd1 || state !== 3'd0) begin
      errors++; $display("FAIL nolock_try1: retry %0d state %0d want 1 0", retry_cnt, state);
    end
    tick(23);
    checks++; if (retry_cnt !== 4'd1 || state !== 3'd1) begin
      errors++; $display("FAIL nolock_wait2: retry %0d state %0d want 1 1", retry_cnt, state);
    end
    tick(1);
    checks++; if (retry_cnt !== 4'd2 || state !== 3'd0) begin
      errors++; $display("FAIL nolock_try2: retry %0d state %0d want 2 0", retry_cnt, state);
    end
    tick(24);
    checks++; if (state !== 3'd4 || fault !== 1'b1 || pll_rst !== 1'b1 || retry_cnt !== 4'd2 || clk_ok !== 1'b0) begin
      errors++; $display("FAIL nolock_fault: state %0d fault %b pll_rst %b retry %0d clk_ok %b want 4 1 1 2 0",
                         state, fault, pll_rst, retry_cnt, clk_ok);
    end
    tick(10);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL fault_hold: got %0d want 4", state); end
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++; if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin
      errors++; $display("FAIL fault_clr: state %0d fault %b retry %0d pll_rst %b want 0 0 0 1", state, fault, retry_cnt, pll_rst);
    end
    tick(72);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL refault: got %0d want 4", state); end
    sw_reset = 1'b1;
    tick(1);
    sw_reset = 1'b0;
    checks++; if (state !== 3'd0 || fault !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL sw_in_fault: state %0d fault %b retry %0d want 0 0 0", state, fault, retry_cnt);
    end
  endtask

  task automatic test_glitch();
    int n;
    pll_locked = 1'b0;
    do_reset();
    wait_pll_rst(1'b0, n);
    pll_locked = 1'b1;
    tick(4);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL glitch_stable: got %0d want 2", state); end
    tick(1);
    pll_locked = 1'b0;
    wait_state(3'd0, n);
    checks++; if (n != 3) begin errors++; $display("FAIL glitch_fail_lat: got %0d want 3", n); end
    checks++; if (retry_cnt !== 4'd1 || pll_rst !== 1'b1 || saw_clk_ok !== 1'b0) begin
      errors++; $display("FAIL glitch_status: retry %0d pll_rst %b saw_clk_ok %b want 1 1 0", retry_cnt, pll_rst, saw_clk_ok);
    end
  endtask

  task automatic test_async_reset();
    int n;
    pll_locked = 1'b0;
    do_reset();
    wait_pll_rst(1'b0, n);
    pll_locked = 1'b1;
    tick(4);
    checks++; if (state !== 3'd2 || pll_rst !== 1'b0) begin
      errors++; $display("FAIL async_pre: state %0d pll_rst %b want 2 0", state, pll_rst);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || state !== 3'd0 || clk_ok !== 1'b0) begin
      errors++; $display("FAIL async_now: pll_rst %b state %0d clk_ok %b want 1 0 0", pll_rst, state, clk_ok);
    end
    rst_n = 1'b1;
    wait_pll_rst(1'b0, n);
    checks++; if (n != 4) begin errors++; $display("FAIL async_restart_rst: got %0d want 4", n); end
    wait_clk_ok(1'b1, n);
    checks++; if (n != 9) begin errors++; $display("FAIL async_restart_run: got %0d want 9", n); end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_lock_loss();
    test_simultaneous();
    test_no_lock();
    test_glitch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
